// File: rtl/cdb_arbiter.sv
// Common data bus transmit end: per-source result FIFOs drained by a round-robin
// arbiter that packs up to CDB_LANES results per cycle onto registered broadcast lanes.
module cdb_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int CDB_LANES  = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int ROB_W      = 6,
   parameter int DATA_W     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [NUM_SRC-1:0]            fu_res_val,
   output logic [NUM_SRC-1:0]            fu_res_rdy,
   input  logic [NUM_SRC*ROB_W-1:0]      fu_robid,
   input  logic [NUM_SRC*6-1:0]          fu_op,
   input  logic [NUM_SRC*5-1:0]          fu_rd,
   input  logic [NUM_SRC*DATA_W-1:0]     fu_data,
   output logic [CDB_LANES*ROB_W-1:0]    robid_cdb,
   output logic [CDB_LANES*6-1:0]        op_cdb,
   output logic [CDB_LANES*5-1:0]        rd_tag_cdb,
   output logic [CDB_LANES-1:0]          commit_instr_cdb,
   output logic [CDB_LANES*DATA_W-1:0]   result_data_cdb
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int LANE_W = (CDB_LANES > 1) ? $clog2(CDB_LANES) : 1;
   localparam int ENT_W  = ROB_W + 6 + 5 + DATA_W;

   logic [ENT_W-1:0]     mem [NUM_SRC][FIFO_DEPTH];
   logic [PTR_W-1:0]     head [NUM_SRC];
   logic [PTR_W-1:0]     tail [NUM_SRC];
   logic [CNT_W-1:0]     count [NUM_SRC];
   logic [ENT_W-1:0]     in_ent [NUM_SRC];
   logic [ENT_W-1:0]     lane_ent [CDB_LANES];
   logic [CDB_LANES-1:0] lane_val;
   logic [NUM_SRC-1:0]   push;
   logic [NUM_SRC-1:0]   pop;
   logic [SRC_W-1:0]     rr_ptr;
   logic [SRC_W-1:0]     rr_next;
   logic                 live;

   // Ready depends on the registered count only, so a same-cycle pop gives no credit.
   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         fu_res_rdy[s] = live & ~rst & (count[s] < CNT_W'(FIFO_DEPTH));
         push[s]       = fu_res_val[s] & fu_res_rdy[s] & ~flush;
         in_ent[s]     = {fu_robid[s*ROB_W +: ROB_W], fu_op[s*6 +: 6],
                          fu_rd[s*5 +: 5], fu_data[s*DATA_W +: DATA_W]};
      end
   end

   always_comb begin
      int n;
      int idx;
      pop      = '0;
      lane_val = '0;
      rr_next  = rr_ptr;
      for (int k = 0; k < CDB_LANES; k++) lane_ent[k] = '0;
      n = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (count[SRC_W'(idx)] != '0 && n < CDB_LANES) begin
            pop[SRC_W'(idx)]      = 1'b1;
            lane_val[LANE_W'(n)]  = 1'b1;
            lane_ent[LANE_W'(n)]  = mem[SRC_W'(idx)][head[SRC_W'(idx)]];
            rr_next               = SRC_W'((idx + 1) % NUM_SRC);
            n                     = n + 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         live             <= 1'b0;
         rr_ptr           <= '0;
         robid_cdb        <= '0;
         op_cdb           <= '0;
         rd_tag_cdb       <= '0;
         commit_instr_cdb <= '0;
         result_data_cdb  <= '0;
         for (int s = 0; s < NUM_SRC; s++) begin
            head[s]  <= '0;
            tail[s]  <= '0;
            count[s] <= '0;
         end
      end else if (flush) begin
         live             <= 1'b1;
         robid_cdb        <= '0;
         op_cdb           <= '0;
         rd_tag_cdb       <= '0;
         commit_instr_cdb <= '0;
         result_data_cdb  <= '0;
         for (int s = 0; s < NUM_SRC; s++) begin
            head[s]  <= '0;
            tail[s]  <= '0;
            count[s] <= '0;
         end
      end else begin
         live   <= 1'b1;
         rr_ptr <= rr_next;
         for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
               mem[s][tail[s]] <= in_ent[s];
               tail[s]         <= tail[s] + 1'b1;
            end
            if (pop[s]) head[s] <= head[s] + 1'b1;
            count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
         end
         // Unused lanes carry an all-zero entry from the arbiter.
         for (int k = 0; k < CDB_LANES; k++) begin
            commit_instr_cdb[k]                  <= lane_val[k];
            result_data_cdb[k*DATA_W +: DATA_W]  <= lane_ent[k][0 +: DATA_W];
            rd_tag_cdb[k*5 +: 5]                 <= lane_ent[k][DATA_W +: 5];
            op_cdb[k*6 +: 6]                     <= lane_ent[k][DATA_W+5 +: 6];
            robid_cdb[k*ROB_W +: ROB_W]          <= lane_ent[k][DATA_W+11 +: ROB_W];
         end
      end
   end

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo_chk
      assert property (@(posedge clk) disable iff (rst) count[s] <= CNT_W'(FIFO_DEPTH));
      assert property (@(posedge clk) disable iff (rst) pop[s] |-> (count[s] != '0));
   end
   assert property (@(posedge clk) disable iff (rst) $countones(commit_instr_cdb) <= CDB_LANES);
   assert property (@(posedge clk) disable iff (rst)
                    (commit_instr_cdb & (commit_instr_cdb + 1'b1)) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked against
// a queue-level model of the per-source FIFOs and the round-robin lane packing.
module tb_cdb_arbiter;

   localparam int NS     = 4;
   localparam int LANES  = 2;
   localparam int DEPTH  = 2;
   localparam int ROB_W  = 6;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [ROB_W-1:0]  robid;
      logic [5:0]        op;
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
   } res_t;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      flush;
   logic [NS-1:0]             fu_res_val;
   logic [NS-1:0]             fu_res_rdy;
   logic [NS*ROB_W-1:0]       fu_robid;
   logic [NS*6-1:0]           fu_op;
   logic [NS*5-1:0]           fu_rd;
   logic [NS*DATA_W-1:0]      fu_data;
   logic [LANES*ROB_W-1:0]    robid_cdb;
   logic [LANES*6-1:0]        op_cdb;
   logic [LANES*5-1:0]        rd_tag_cdb;
   logic [LANES-1:0]          commit_instr_cdb;
   logic [LANES*DATA_W-1:0]   result_data_cdb;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_SRC(NS), .CDB_LANES(LANES), .FIFO_DEPTH(DEPTH),
                 .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fu_res_val(fu_res_val), .fu_res_rdy(fu_res_rdy),
      .fu_robid(fu_robid), .fu_op(fu_op), .fu_rd(fu_rd), .fu_data(fu_data),
      .robid_cdb(robid_cdb), .op_cdb(op_cdb), .rd_tag_cdb(rd_tag_cdb),
      .commit_instr_cdb(commit_instr_cdb), .result_data_cdb(result_data_cdb)
   );

   res_t           mq [NS][$];
   int             mrr;
   bit             mlive;
   res_t           src [NS];
   bit             pend [NS];
   int             nCompared;
   int             nMismatched;
   int             seq;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic loadSource(input int s, input logic [ROB_W-1:0] robid, input logic [5:0] op,
                             input logic [4:0] rd, input logic [DATA_W-1:0] data);
      src[s].robid = robid;
      src[s].op    = op;
      src[s].rd    = rd;
      src[s].data  = data;
      pend[s]      = 1'b1;
   endtask

   task automatic loadRandom(input int s);
      loadSource(s, ROB_W'($urandom), 6'($urandom), 5'($urandom), $urandom);
   endtask

   // One clock cycle: drive pending sources, check ready, advance the model, check the lanes.
   task automatic applyStimulus();
      logic [NS-1:0]           exp_rdy;
      logic [NS-1:0]           acc;
      res_t                    exp_lane [LANES];
      logic [LANES-1:0]        exp_commit;
      logic [LANES*ROB_W-1:0]  e_robid;
      logic [LANES*6-1:0]      e_op;
      logic [LANES*5-1:0]      e_rd;
      logic [LANES*DATA_W-1:0] e_data;
      int n;
      int s;
      int last;
      for (int i = 0; i < NS; i++) begin
         fu_res_val[i]                  = pend[i];
         fu_robid[i*ROB_W +: ROB_W]     = src[i].robid;
         fu_op[i*6 +: 6]                = src[i].op;
         fu_rd[i*5 +: 5]                = src[i].rd;
         fu_data[i*DATA_W +: DATA_W]    = src[i].data;
      end
      #1;
      for (int i = 0; i < NS; i++) begin
         exp_rdy[i] = mlive && !rst && (mq[i].size() < DEPTH);
         acc[i]     = pend[i] && exp_rdy[i] && !flush && !rst;
      end
      checkOutput("rdy", 128'(fu_res_rdy), 128'(exp_rdy));
      @(posedge clk);
      exp_commit = '0;
      last = 0;
      for (int k = 0; k < LANES; k++) exp_lane[k] = '0;
      mlive = !rst;
      if (rst || flush) begin
         for (int i = 0; i < NS; i++) mq[i].delete();
         if (rst) mrr = 0;
      end else begin
         n = 0;
         for (int i = 0; i < NS; i++) begin
            s = (mrr + i) % NS;
            if (mq[s].size() > 0 && n < LANES) begin
               exp_lane[n]   = mq[s].pop_front();
               exp_commit[n] = 1'b1;
               last          = s;
               n++;
            end
         end
         if (n > 0) mrr = (last + 1) % NS;
         for (int i = 0; i < NS; i++) if (acc[i]) mq[i].push_back(src[i]);
      end
      for (int i = 0; i < NS; i++) if (acc[i] || rst || flush) pend[i] = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         e_robid[k*ROB_W +: ROB_W]   = exp_lane[k].robid;
         e_op[k*6 +: 6]              = exp_lane[k].op;
         e_rd[k*5 +: 5]              = exp_lane[k].rd;
         e_data[k*DATA_W +: DATA_W]  = exp_lane[k].data;
      end
      #1;
      checkOutput("commit", 128'(commit_instr_cdb), 128'(exp_commit));
      checkOutput("robid",  128'(robid_cdb),        128'(e_robid));
      checkOutput("op",     128'(op_cdb),           128'(e_op));
      checkOutput("rd",     128'(rd_tag_cdb),       128'(e_rd));
      checkOutput("data",   128'(result_data_cdb),  128'(e_data));
      @(negedge clk);
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      mrr         = 0;
      mlive       = 1'b0;
      seq         = 0;
      rst         = 1'b1;
      flush       = 1'b0;
      fu_res_val  = '0;
      fu_robid    = '0;
      fu_op       = '0;
      fu_rd       = '0;
      fu_data     = '0;
      for (int i = 0; i < NS; i++) begin
         pend[i] = 1'b0;
         src[i]  = '0;
      end
      @(negedge clk);

      // Reset held three cycles, then ready rises one cycle after release.
      repeat (3) applyStimulus();
      checkOutput("t1_cdb_zero", 128'(commit_instr_cdb), 128'(0));
      rst = 1'b0;
      repeat (2) applyStimulus();
      checkOutput("t1_rdy_up", 128'(fu_res_rdy), 128'(4'hF));

      // Single result from source 2 appears on lane 0 for exactly one cycle.
      loadSource(2, 6'd5, 6'h11, 5'd7, 32'hDEADBEEF);
      applyStimulus();
      applyStimulus();
      checkOutput("t2_commit", 128'(commit_instr_cdb), 128'(2'b01));
      checkOutput("t2_robid",  128'(robid_cdb[ROB_W-1:0]), 128'(6'd5));
      checkOutput("t2_rd",     128'(rd_tag_cdb[4:0]), 128'(5'd7));
      checkOutput("t2_data",   128'(result_data_cdb[DATA_W-1:0]), 128'(32'hDEADBEEF));
      applyStimulus();
      checkOutput("t2_once", 128'(commit_instr_cdb), 128'(0));

      // Saturating traffic from every source after a fresh reset; robid low bits name the source.
      rst = 1'b1;
      repeat (2) applyStimulus();
      rst = 1'b0;
      applyStimulus();
      for (int c = 0; c < 12; c++) begin
         for (int s = 0; s < NS; s++) begin
            if (!pend[s]) begin
               loadSource(s, ROB_W'((seq << 2) | s), 6'(s), 5'(seq), DATA_W'(seq * 16 + s));
               seq++;
            end
         end
         applyStimulus();
         if (c == 1) checkOutput("t3_grant01", 128'({robid_cdb[ROB_W +: 2], robid_cdb[1:0]}), 128'(4'b0100));
         if (c == 2) checkOutput("t3_grant23", 128'({robid_cdb[ROB_W +: 2], robid_cdb[1:0]}), 128'(4'b1110));
      end

      // Flush with full FIFOs and pushes in the flush cycle: everything is discarded.
      for (int s = 0; s < NS; s++) if (!pend[s]) loadRandom(s);
      flush = 1'b1;
      applyStimulus();
      flush = 1'b0;
      checkOutput("t6_cdb_zero", 128'(commit_instr_cdb), 128'(0));
      checkOutput("t6_data_zero", 128'(result_data_cdb), 128'(0));
      checkOutput("t6_rdy", 128'(fu_res_rdy), 128'(4'hF));
      repeat (3) applyStimulus();

      // Random traffic with occasional flush and reset.
      for (int c = 0; c < 800; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 39) == 0);
         for (int s = 0; s < NS; s++)
            if (!pend[s] && $urandom_range(0, 99) < 60) loadRandom(s);
         applyStimulus();
      end
      rst   = 1'b0;
      flush = 1'b0;
      repeat (10) applyStimulus();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
